// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM word port between a load/store unit (A)
// and a loader/debug master (B). Each transaction runs IDLE -> ACCESS -> DONE.
module mem_port_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS  = 16384,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_data_i,
  input  logic [3:0]  a_wr_i,
  output logic        a_ack_o,
  output logic [31:0] a_rdata_o,
  output logic        a_err_o,
  input  logic        b_req_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_data_i,
  input  logic [3:0]  b_wr_i,
  output logic        b_ack_o,
  output logic [31:0] b_rdata_o,
  output logic        b_err_o,
  output logic [13:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_wr_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        last_b_q;
  logic        grant_b_q;
  logic [13:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  wr_q;
  logic        err_q;
  logic [31:0] a_rdata_q, b_rdata_q;

  logic        any_req;
  logic        pick_b;
  logic [31:0] sel_addr;
  logic [31:0] word;
  logic        in_window;

  always_comb begin
    any_req = a_req_i | b_req_i;
    if (!a_req_i)        pick_b = 1'b1;
    else if (!b_req_i)   pick_b = 1'b0;
    else if (FIXED_PRIO) pick_b = 1'b0;
    else                 pick_b = ~last_b_q;
    sel_addr  = pick_b ? b_addr_i : a_addr_i;
    // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
    word      = (sel_addr - BASE_ADDR) >> 2;
    in_window = (word < MEM_WORDS);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      last_b_q  <= 1'b1;
      grant_b_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= '0;
      err_q     <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            grant_b_q <= pick_b;
            addr_q    <= word[13:0];
            data_q    <= pick_b ? b_data_i : a_data_i;
            wr_q      <= in_window ? (pick_b ? b_wr_i : a_wr_i) : 4'b0000;
            err_q     <= ~in_window;
          end
        end
        S_ACCESS: begin
          last_b_q <= grant_b_q;
          // Read-first RAM: this edge captures the value before the write lands.
          if (grant_b_q) b_rdata_q <= err_q ? 32'h0 : mem_data_i;
          else           a_rdata_q <= err_q ? 32'h0 : mem_data_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = any_req ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o = addr_q;
    mem_data_o = data_q;
    mem_wr_o   = (state_q == S_ACCESS) ? wr_q : 4'b0000;
    a_ack_o    = (state_q == S_DONE) & ~grant_b_q;
    b_ack_o    = (state_q == S_DONE) &  grant_b_q;
    a_err_o    = a_ack_o & err_q;
    b_err_o    = b_ack_o & err_q;
    a_rdata_o  = a_rdata_q;
    b_rdata_o  = b_rdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (BASE 0 round-robin, BASE 0x1000
// fixed priority) each backed by a read-first RAM, driven by shared requests.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        a_req, b_req;
  logic [31:0] a_addr, a_data, b_addr, b_data;
  logic [3:0]  a_wr, b_wr;

  logic        a_ack0, b_ack0, a_err0, b_err0, a_ack1, b_ack1, a_err1, b_err1;
  logic [31:0] a_rd0, b_rd0, a_rd1, b_rd1;
  logic [13:0] maddr0, maddr1;
  logic [31:0] mdo0, mdo1, mdi0, mdi1;
  logic [3:0]  mwr0, mwr1;

  logic [31:0] ram0 [16384];
  logic [31:0] ram1 [16384];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.BASE_ADDR(32'h0000_0000), .MEM_WORDS(16384), .FIXED_PRIO(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_data_i(a_data), .a_wr_i(a_wr),
    .a_ack_o(a_ack0), .a_rdata_o(a_rd0), .a_err_o(a_err0),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_data_i(b_data), .b_wr_i(b_wr),
    .b_ack_o(b_ack0), .b_rdata_o(b_rd0), .b_err_o(b_err0),
    .mem_addr_o(maddr0), .mem_data_o(mdo0), .mem_wr_o(mwr0), .mem_data_i(mdi0)
  );

  mem_port_arbiter #(.BASE_ADDR(32'h0000_1000), .MEM_WORDS(16384), .FIXED_PRIO(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_addr_i(a_addr), .a_data_i(a_data), .a_wr_i(a_wr),
    .a_ack_o(a_ack1), .a_rdata_o(a_rd1), .a_err_o(a_err1),
    .b_req_i(b_req), .b_addr_i(b_addr), .b_data_i(b_data), .b_wr_i(b_wr),
    .b_ack_o(b_ack1), .b_rdata_o(b_rd1), .b_err_o(b_err1),
    .mem_addr_o(maddr1), .mem_data_o(mdo1), .mem_wr_o(mwr1), .mem_data_i(mdi1)
  );

  assign mdi0 = ram0[maddr0];
  assign mdi1 = ram1[maddr1];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16384; i++) begin
        ram0[i] <= '0;
        ram1[i] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mwr0[k]) ram0[maddr0][8*k +: 8] <= mdo0[8*k +: 8];
        if (mwr1[k]) ram1[maddr1][8*k +: 8] <= mdo1[8*k +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_b;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  wr;
    logic [31:0] rd0;
    bit          err0;
    logic [31:0] rd1;
    bit          err1;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          got;
    logic [13:0] acc_addr0;
    logic [3:0]  acc_wr0, acc_wr1;
    logic [31:0] r0, r1;
    logic        e0, e1;
    int          n0, n1, both0, both1, cnt;
    logic        ord0 [4];
    logic        ord1 [4];
    int          t0 [4];

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0, 32'h0, 1'b1};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0, 32'h0, 1'b1};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 32'h1122_3344, 1'b0, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h1122_33AA, 1'b0, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0000_001C, 32'h0000_0099, 4'hF, 32'h0000_0000, 1'b0, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0000_001C, 32'h0000_0055, 4'hF, 32'h0000_0099, 1'b0, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0000_001C, 32'h0,         4'h0, 32'h0000_0055, 1'b0, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'hDEAD_0001, 4'hF, 32'h0000_0000, 1'b0, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hDEAD_0001, 1'b0, 32'h0, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_1000, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0};
    vecs[12] = '{1'b0, 32'h0001_0FFC, 32'h0,         4'h0, 32'h0000_0000, 1'b1, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 32'h0001_1000, 32'h0,         4'h0, 32'h0000_0000, 1'b1, 32'h0, 1'b1};

    rst = 1'b1; clr = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    a_addr = '0; a_data = '0; a_wr = '0;
    b_addr = '0; b_data = '0; b_wr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; clr = 1'b0;

    check("reset acks", {30'h0, a_ack0, b_ack0}, 32'h0);
    check("reset errs", {30'h0, a_err0, b_err0}, 32'h0);
    check("reset rdata a", a_rd0, 32'h0);
    check("reset rdata b", b_rd0, 32'h0);
    check("reset mem_addr", {18'h0, maddr0}, 32'h0);
    check("reset mem_data", mdo0, 32'h0);
    check("reset mem_wr", {28'h0, mwr0}, 32'h0);

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].is_b) begin
        b_req = 1'b1; b_addr = vecs[v].addr; b_data = vecs[v].data; b_wr = vecs[v].wr;
      end else begin
        a_req = 1'b1; a_addr = vecs[v].addr; a_data = vecs[v].data; a_wr = vecs[v].wr;
      end
      lat = 0; got = 1'b0;
      acc_addr0 = '0; acc_wr0 = '0; acc_wr1 = '0;
      while (!got && lat < 6) begin
        @(posedge clk); lat++; @(negedge clk);
        if (lat == 1) begin
          acc_addr0 = maddr0; acc_wr0 = mwr0; acc_wr1 = mwr1;
        end
        if (a_ack0 | b_ack0) got = 1'b1;
      end
      r0 = vecs[v].is_b ? b_rd0 : a_rd0;
      r1 = vecs[v].is_b ? b_rd1 : a_rd1;
      e0 = vecs[v].is_b ? b_err0 : a_err0;
      e1 = vecs[v].is_b ? b_err1 : a_err1;
      check($sformatf("v%0d latency", v), lat, 2);
      check($sformatf("v%0d acks0", v), {30'h0, a_ack0, b_ack0}, vecs[v].is_b ? 32'h1 : 32'h2);
      check($sformatf("v%0d acks1", v), {30'h0, a_ack1, b_ack1}, vecs[v].is_b ? 32'h1 : 32'h2);
      check($sformatf("v%0d mem_addr0", v), {18'h0, acc_addr0}, {18'h0, vecs[v].addr[15:2]});
      check($sformatf("v%0d mem_wr0", v), {28'h0, acc_wr0}, vecs[v].err0 ? 32'h0 : {28'h0, vecs[v].wr});
      check($sformatf("v%0d mem_wr1", v), {28'h0, acc_wr1}, vecs[v].err1 ? 32'h0 : {28'h0, vecs[v].wr});
      check($sformatf("v%0d rdata0", v), r0, vecs[v].rd0);
      check($sformatf("v%0d err0", v), {31'h0, e0}, {31'h0, vecs[v].err0});
      check($sformatf("v%0d rdata1", v), r1, vecs[v].rd1);
      check($sformatf("v%0d err1", v), {31'h0, e1}, {31'h0, vecs[v].err1});
      a_req = 1'b0; b_req = 1'b0;
      @(posedge clk); @(negedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rdata hold b", b_rd0, 32'hCAFE_F00D);
    check("no spurious ack", {30'h0, a_ack0, b_ack0}, 32'h0);

    // Contention: both requesters held high straight out of reset.
    rst = 1'b1;
    a_req = 1'b1; a_addr = 32'h100; a_wr = 4'h0;
    b_req = 1'b1; b_addr = 32'h104; b_wr = 4'h0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    n0 = 0; n1 = 0; both0 = 0; both1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (a_ack0 && b_ack0) both0++;
      if (a_ack1 && b_ack1) both1++;
      if ((a_ack0 | b_ack0) && n0 < 4) begin
        ord0[n0] = b_ack0; t0[n0] = c; n0++;
      end
      if ((a_ack1 | b_ack1) && n1 < 4) begin
        ord1[n1] = b_ack1; n1++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("rr ack count", n0, 4);
    check("fixed ack count", n1, 4);
    check("rr simultaneous", both0, 0);
    check("fixed simultaneous", both1, 0);
    if (n0 == 4) begin
      check("rr order", {28'h0, ord0[0], ord0[1], ord0[2], ord0[3]}, 32'b0101);
      check("rr first ack cycle", t0[0], 1);
      for (int i = 0; i < 3; i++) check($sformatf("rr spacing %0d", i), t0[i+1] - t0[i], 3);
    end
    if (n1 == 4) check("fixed order", {28'h0, ord1[0], ord1[1], ord1[2], ord1[3]}, 32'b0000);
    @(posedge clk); @(negedge clk);

    // Reset while a B write is in ACCESS.
    b_req = 1'b1; b_addr = 32'h40; b_data = 32'h1234_5678; b_wr = 4'hF;
    @(posedge clk); @(negedge clk);
    check("abort in access wr", {28'h0, mwr0}, 32'hF);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; b_req = 1'b0;
    check("abort mem_wr", {28'h0, mwr0}, 32'h0);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (b_ack0 | a_ack0) cnt++;
      @(posedge clk); @(negedge clk);
    end
    check("abort no ack", cnt, 0);

    a_req = 1'b1; a_addr = 32'h44; a_wr = 4'h0;
    b_req = 1'b1; b_addr = 32'h48; b_wr = 4'h0;
    lat = 0; got = 1'b0;
    while (!got && lat < 6) begin
      @(posedge clk); lat++; @(negedge clk);
      if (a_ack0 | b_ack0) got = 1'b1;
    end
    check("post-reset latency", lat, 2);
    check("post-reset winner", {30'h0, a_ack0, b_ack0}, 32'h2);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one word port of the 16K x 32 dual-port data RAM (14-bit word address, 4-bit byte write enables, asynchronous read) between two requesters.
  - Requester A: the core's load/store unit.
  - Requester B: the testbench loader/debug master.
- Round-robin arbitration with a req/ack handshake, registered memory-side signals, address window check and an error flag.
- Sits between the requesters and RAM port 1; port 0 is unaffected.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of RAM word 0; must be 4-byte aligned.
- MEM_WORDS, 16384, number of 32-bit words in the RAM window.
- FIXED_PRIO, 0, 1 = A always wins ties; 0 = round-robin.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- a_req_i  in  1  A request; held until a_ack_o
- a_addr_i  in  32  A byte address; bits [1:0] ignored
- a_data_i  in  32  A write data
- a_wr_i  in  4  A byte write enables; 0 = read
- a_ack_o  out  1  one-cycle completion pulse
- a_rdata_o  out  32  read data, valid while a_ack_o
- a_err_o  out  1  out-of-window flag, valid while a_ack_o
- b_req_i, b_addr_i, b_data_i, b_wr_i, b_ack_o, b_rdata_o, b_err_o  (same as A, for requester B)
- mem_addr_o  out  14  RAM word address
- mem_data_o  out  32  RAM write data
- mem_wr_o  out  4  RAM byte write enables
- mem_data_i  in  32  RAM read data (combinational from mem_addr_o)

Behaviour:
- Reset (rst_i sampled high):
  - State IDLE, last_grant = B, so A wins the first tie.
  - All ack/err outputs 0; rdata outputs 0.
  - mem_addr_o 0, mem_data_o 0, mem_wr_o 0.
  - Reset during ACCESS or DONE aborts the transaction: no ack is issued, and mem_wr_o is 0 from the next cycle.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE with mem_wr_o = 0.
  - One request: grant it.
  - Both requesting: grant the requester that is not last_grant; if FIXED_PRIO = 1, grant A.
  - On grant, register the winner's addr/data/wr and move to ACCESS.
- Window check (in IDLE, on the winner's address):
  - word = (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic, so addresses below BASE_ADDR wrap to large values.
  - in_window = word < MEM_WORDS.
  - mem_addr_o = word[13:0].
  - If not in_window: mem_wr_o is forced to 0 and err is latched to 1.
- ACCESS (exactly one cycle):
  - mem_addr_o, mem_data_o and mem_wr_o are driven from registers; the RAM write commits on the closing edge.
  - mem_data_i is captured into the winner's rdata register on that edge; the RAM is read-first, so this is the pre-write value.
  - For an out-of-window access the captured rdata is 0.
  - Next state DONE; last_grant = winner.
- DONE (exactly one cycle):
  - The winner's ack_o is 1 and its rdata_o/err_o are valid; the loser's ack_o is 0.
  - mem_wr_o = 0.
  - Next state is always IDLE, so a still-high req is not re-served in the same cycle.
  - Requesters drop req or present a new transaction after seeing ack.
- Latency: req high at edge N (state IDLE) -> ACCESS during cycle N+1 -> ack during cycle N+2. Peak throughput is one transaction per 3 cycles.
- Outside ACCESS, mem_wr_o is 0. rdata_o holds its last value between acks.
- Request stability: a requester must not change addr/data/wr while req is high. The arbiter samples them once, in IDLE.
- Fairness: with both requesters continuously requesting, grants strictly alternate A, B, A, B (FIXED_PRIO = 0).
- req with wr = 4'b0000 is a plain read. Partial byte enables update only the enabled bytes.
- ack is never asserted to both requesters in the same cycle, and never without a prior grant.

Test Plan:
- A write then read: A writes addr 0x10, data 0xDEADBEEF, wr 4'hF -> a_ack_o at cycle +2, mem_addr_o = 4 during ACCESS. A then reads 0x10 -> a_rdata_o = 0xDEADBEEF, a_err_o = 0.
- Byte enable: B writes 0x000000AA with wr 4'b0001 to a word holding 0x11223344 -> a read returns 0x112233AA.
- Contention: a_req_i and b_req_i both held high from reset for 4 transactions -> ack order A, B, A, B, each ack 3 cycles apart, never simultaneous. With FIXED_PRIO = 1 -> A, A, A, A.
- Window: BASE_ADDR = 0x1000. A writes to addr 0x0FFC (wraps below base) -> mem_wr_o stays 0, a_err_o = 1, a_rdata_o = 0. Byte addr 0x1000 + 4*16384 -> a_err_o = 1.
- Reset mid-operation: assert rst_i during ACCESS of a B write -> no b_ack_o, state IDLE. The next A request is acked in 2 cycles after IDLE sampling and wins first (last_grant = B).
- Read-first: A writes 0x55 to word 7 while the word holds 0x99 -> the A ack returns rdata 0x99; a following read returns 0x55.
